// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave fronting an asynchronous SRAM, with configurable width and wait states.
// Writes run setup / pulse / hold; out-of-range or empty-select requests terminate with err_o.
module wb_sram_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 20,
  parameter int MEM_WORDS = 2**ADDR_W,
  parameter int RD_WAIT   = 1,
  parameter int WR_WAIT   = 1
) (
  input  logic                clk_bus,
  input  logic                rst_bus,
  input  logic [DATA_W-1:0]   dat_i,
  output logic [DATA_W-1:0]   dat_o,
  output logic                ack_o,
  input  logic [31:0]         adr_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  output logic                err_o,
  output logic                rty_o,
  output logic [ADDR_W-1:0]   sram_adr,
  inout  wire  [DATA_W-1:0]   sram_dat,
  output logic                sram_ce,
  output logic                sram_oe,
  output logic                sram_we,
  output logic [DATA_W/8-1:0] sram_be
);

  localparam int SEL_W    = DATA_W / 8;
  localparam int LSB      = $clog2(SEL_W);
  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK, ERR
  } state_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    sel_q, sel_nxt;
  logic [DATA_W-1:0]   wr_q, rd_mask;
  logic [ADDR_W-1:0]   req_idx;
  logic                req_valid, idx_oob, next_access, drive_en, aborted;
  logic                unused_adr;

  assign req_idx    = adr_i[ADDR_W+LSB-1:LSB];
  assign idx_oob    = {1'b0, req_idx} >= MEM_LIMIT;
  assign req_valid  = (state == IDLE) && cyc_i && stb_i;
  assign unused_adr = ^adr_i;
  assign rty_o      = 1'b0;
  assign sram_dat   = drive_en ? wr_q : 'z;

  // Lane selects are latched on the accepting edge, so use the live ones there.
  assign sel_nxt     = (state == IDLE) ? sel_i : sel_q;
  assign next_access = (next_state == RD) || (next_state == WR_SETUP) ||
                       (next_state == WR_PULSE) || (next_state == WR_HOLD);

  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < SEL_W; i++) rd_mask[i*8 +: 8] = {8{sel_q[i]}};
  end

  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cyc_i && stb_i) begin
          if (sel_i == '0 || idx_oob) next_state = ERR;
          else if (we_i)              next_state = WR_SETUP;
          else                        next_state = RD;
        end
      end
      RD:       if (cnt == '0) next_state = ACK;
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: if (cnt == '0) next_state = WR_HOLD;
      WR_HOLD:  next_state = ACK;
      ACK:      next_state = IDLE;
      ERR:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      cnt <= '0;
    end else if (state != RD && next_state == RD) begin
      cnt <= CNT_W'(RD_WAIT - 1);
    end else if (state != WR_PULSE && next_state == WR_PULSE) begin
      cnt <= CNT_W'(WR_WAIT - 1);
    end else if ((state == RD || state == WR_PULSE) && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Pins are decoded from next_state into flops so they never glitch.
  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
      sram_ce  <= 1'b1;
      sram_oe  <= 1'b1;
      sram_we  <= 1'b1;
      sram_be  <= '1;
      sram_adr <= '0;
      sel_q    <= '0;
      wr_q     <= '0;
      drive_en <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      ack_o    <= (next_state == ACK) && cyc_i && !aborted;
      err_o    <= (next_state == ERR) && cyc_i;
      sram_ce  <= !next_access;
      sram_oe  <= (next_state != RD);
      sram_we  <= (next_state != WR_PULSE);
      sram_be  <= next_access ? ~sel_nxt : '1;
      drive_en <= (next_state == WR_SETUP) || (next_state == WR_PULSE) ||
                  (next_state == WR_HOLD);
      if (state == IDLE)  aborted <= 1'b0;
      else if (!cyc_i)    aborted <= 1'b1;
      if (req_valid) begin
        sram_adr <= req_idx;
        sel_q    <= sel_i;
        wr_q     <= dat_i;
      end
      if (state == RD && cnt == '0) dat_o <= sram_dat & rd_mask;
    end
  end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench for wb_sram_ctrl: two instances (1/1 and 3/2 wait states) each backed by a small SRAM model.
module tb_wb_sram_ctrl;

  logic        clk_bus = 1'b0;
  logic        rst_bus;
  logic [31:0] dat_i, adr_i;
  logic        cyc_i, we_i, stb0, stb1;
  logic [3:0]  sel_i;

  logic [31:0] dat_o0, dat_o1;
  logic        ack0, ack1, err0, err1, rty0, rty1;
  logic [19:0] adr0;
  logic [9:0]  adr1;
  wire  [31:0] sram_dat0, sram_dat1;
  logic        ce0, oe0, we0, ce1, oe1, we1;
  logic [3:0]  be0, be1;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];

  int n_checks = 0;
  int n_fail   = 0;

  int lat, we_low, oe_low, ce_low, be_bad, adr_bad, both_hi;
  bit got_ack, got_err, first_we_hi;

  always #5 clk_bus = ~clk_bus;

  wb_sram_ctrl #(.DATA_W(32), .ADDR_W(20), .MEM_WORDS(1024), .RD_WAIT(1), .WR_WAIT(1)) dut0 (
    .clk_bus(clk_bus), .rst_bus(rst_bus), .dat_i(dat_i), .dat_o(dat_o0), .ack_o(ack0),
    .adr_i(adr_i), .cyc_i(cyc_i), .stb_i(stb0), .we_i(we_i), .sel_i(sel_i),
    .err_o(err0), .rty_o(rty0), .sram_adr(adr0), .sram_dat(sram_dat0),
    .sram_ce(ce0), .sram_oe(oe0), .sram_we(we0), .sram_be(be0)
  );

  wb_sram_ctrl #(.DATA_W(32), .ADDR_W(10), .RD_WAIT(3), .WR_WAIT(2)) dut1 (
    .clk_bus(clk_bus), .rst_bus(rst_bus), .dat_i(dat_i), .dat_o(dat_o1), .ack_o(ack1),
    .adr_i(adr_i), .cyc_i(cyc_i), .stb_i(stb1), .we_i(we_i), .sel_i(sel_i),
    .err_o(err1), .rty_o(rty1), .sram_adr(adr1), .sram_dat(sram_dat1),
    .sram_ce(ce1), .sram_oe(oe1), .sram_we(we1), .sram_be(be1)
  );

  // Asynchronous SRAM models: combinational read, byte-lane write while we is low.
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be_n);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (!be_n[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  assign sram_dat0 = (!ce0 && !oe0) ? mem0[adr0[9:0]] : 'z;
  assign sram_dat1 = (!ce1 && !oe1) ? mem1[adr1]      : 'z;

  always @(posedge clk_bus) begin
    if (!ce0 && !we0) mem0[adr0[9:0]] <= merge(mem0[adr0[9:0]], sram_dat0, be0);
    if (!ce1 && !we1) mem1[adr1]      <= merge(mem1[adr1], sram_dat1, be1);
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  // One bus access on instance 'which'; records SRAM pin activity until termination.
  task automatic applyStimulus(input int which, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] sel,
                               input logic [3:0] exp_be, input logic [19:0] exp_adr);
    logic a, e, ce, oe, we;
    logic [3:0]  be;
    logic [19:0] ad;
    adr_i = addr; dat_i = data; sel_i = sel; we_i = wr;
    cyc_i = 1'b1; stb0 = (which == 0); stb1 = (which == 1);
    lat = 0; we_low = 0; oe_low = 0; ce_low = 0; be_bad = 0; adr_bad = 0; both_hi = 0;
    got_ack = 1'b0; got_err = 1'b0; first_we_hi = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      a  = which ? ack1 : ack0;
      e  = which ? err1 : err0;
      ce = which ? ce1  : ce0;
      oe = which ? oe1  : oe0;
      we = which ? we1  : we0;
      be = which ? be1  : be0;
      ad = which ? {10'd0, adr1} : adr0;
      if (!ce) begin
        ce_low++;
        if (be !== exp_be)  be_bad++;
        if (ad !== exp_adr) adr_bad++;
      end
      if (!we) we_low++;
      if (!oe) oe_low++;
      if (k == 1) first_we_hi = we;
      if (a && e) both_hi++;
      if (a || e) begin
        lat = k; got_ack = a; got_err = e;
        break;
      end
    end
    cyc_i = 1'b0; stb0 = 1'b0; stb1 = 1'b0;
    tick();
  endtask

  initial begin
    int acks_after;
    rst_bus = 1'b0; cyc_i = 1'b0; stb0 = 1'b0; stb1 = 1'b0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0;
    tick(); tick();
    checkOutput("rst_ack",  64'(ack0),   64'(0));
    checkOutput("rst_err",  64'(err0),   64'(0));
    checkOutput("rst_dat",  64'(dat_o0), 64'(0));
    checkOutput("rst_ce",   64'(ce0),    64'(1));
    checkOutput("rst_oe",   64'(oe0),    64'(1));
    checkOutput("rst_we",   64'(we0),    64'(1));
    checkOutput("rst_be",   64'(be0),    64'(4'hF));
    checkOutput("rst_adr",  64'(adr0),   64'(0));
    checkOutput("rty",      64'(rty0),   64'(0));
    rst_bus = 1'b1;
    tick();

    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'h0, 20'd4);
    checkOutput("wr_ack",     64'(got_ack),     64'(1));
    checkOutput("wr_err",     64'(got_err),     64'(0));
    checkOutput("wr_lat",     64'(lat),         64'(4));
    checkOutput("wr_we_low",  64'(we_low),      64'(1));
    checkOutput("wr_ce_low",  64'(ce_low),      64'(3));
    checkOutput("wr_setup",   64'(first_we_hi), 64'(1));
    checkOutput("wr_be",      64'(be_bad),      64'(0));
    checkOutput("wr_adr",     64'(adr_bad),     64'(0));
    checkOutput("wr_mem",     64'(mem0[4]),     64'(32'hDEADBEEF));

    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 4'h0, 20'd4);
    checkOutput("rd_ack",     64'(got_ack), 64'(1));
    checkOutput("rd_lat",     64'(lat),     64'(2));
    checkOutput("rd_oe_low",  64'(oe_low),  64'(1));
    checkOutput("rd_we_low",  64'(we_low),  64'(0));
    checkOutput("rd_dat",     64'(dat_o0),  64'(32'hDEADBEEF));

    applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'b0101, 4'b1010, 20'd8);
    checkOutput("bl_wr_lat",  64'(lat),     64'(4));
    checkOutput("bl_wr_be",   64'(be_bad),  64'(0));
    checkOutput("bl_wr_ce",   64'(ce_low),  64'(3));
    checkOutput("bl_mem",     64'(mem0[8] & 32'h00FF00FF), 64'(32'h00220044));
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'b0101, 4'b1010, 20'd8);
    checkOutput("bl_rd_lat",  64'(lat),     64'(2));
    checkOutput("bl_rd_be",   64'(be_bad),  64'(0));
    checkOutput("bl_rd_dat",  64'(dat_o0),  64'(32'h00220044));

    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'hF, 4'h0, 20'd0);
    checkOutput("oob_err",    64'(got_err), 64'(1));
    checkOutput("oob_ack",    64'(got_ack), 64'(0));
    checkOutput("oob_lat",    64'(lat),     64'(1));
    checkOutput("oob_ce",     64'(ce_low),  64'(0));
    applyStimulus(0, 1'b1, 32'h10, 32'h55555555, 4'h0, 4'h0, 20'd4);
    checkOutput("sel0_err",   64'(got_err), 64'(1));
    checkOutput("sel0_lat",   64'(lat),     64'(1));
    checkOutput("sel0_ce",    64'(ce_low),  64'(0));
    checkOutput("sel0_mem",   64'(mem0[4]), 64'(32'hDEADBEEF));
    checkOutput("both_hi",    64'(both_hi), 64'(0));

    applyStimulus(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 4'h0, 20'd16);
    checkOutput("ws_wr_ack",  64'(got_ack), 64'(1));
    checkOutput("ws_wr_lat",  64'(lat),     64'(5));
    checkOutput("ws_we_low",  64'(we_low),  64'(2));
    checkOutput("ws_wr_ce",   64'(ce_low),  64'(4));
    applyStimulus(1, 1'b0, 32'h40, 32'h0, 4'hF, 4'h0, 20'd16);
    checkOutput("ws_rd_lat",  64'(lat),     64'(4));
    checkOutput("ws_oe_low",  64'(oe_low),  64'(3));
    checkOutput("ws_rd_dat",  64'(dat_o1),  64'(32'hCAFEF00D));

    applyStimulus(0, 1'b1, 32'h30, 32'h5A5AA5A5, 4'hF, 4'h0, 20'd12);
    checkOutput("ab_wr_lat",  64'(lat),     64'(4));
    adr_i = 32'h30; sel_i = 4'hF; we_i = 1'b0; cyc_i = 1'b1; stb0 = 1'b1;
    tick();
    checkOutput("ab_rd_oe",   64'(oe0),     64'(0));
    cyc_i = 1'b0; stb0 = 1'b0;
    tick();
    checkOutput("ab_ack",     64'(ack0),    64'(0));
    checkOutput("ab_dat",     64'(dat_o0),  64'(32'h5A5AA5A5));
    tick();
    checkOutput("ab_ack_idle", 64'(ack0),   64'(0));
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 4'h0, 20'd4);
    checkOutput("ab_next_lat", 64'(lat),    64'(2));
    checkOutput("ab_next_dat", 64'(dat_o0), 64'(32'hDEADBEEF));

    adr_i = 32'h50; dat_i = 32'h12345678; sel_i = 4'hF; we_i = 1'b1; cyc_i = 1'b1; stb0 = 1'b1;
    tick();
    tick();
    checkOutput("mr_pulse_we", 64'(we0),    64'(0));
    #2 rst_bus = 1'b0;
    cyc_i = 1'b0; stb0 = 1'b0;
    #1;
    checkOutput("mr_we",  64'(we0),    64'(1));
    checkOutput("mr_ce",  64'(ce0),    64'(1));
    checkOutput("mr_ack", 64'(ack0),   64'(0));
    checkOutput("mr_be",  64'(be0),    64'(4'hF));
    checkOutput("mr_dat", 64'(dat_o0), 64'(0));
    #1 rst_bus = 1'b1;
    acks_after = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ack0) acks_after++;
    end
    checkOutput("mr_no_ack", 64'(acks_after), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wb_sram_ctrl.md
# wb_sram_ctrl

Parametrised Wishbone classic slave that fronts an external asynchronous SRAM, succeeding the fixed single-cycle 32-bit RAM slave. Data width, SRAM depth and read/write wait states are configurable. Writes use a setup/pulse/hold sequence. Out-of-range and empty-select accesses return `err_o` without touching the SRAM. It sits on the system bus beside the other memory-mapped slaves and owns the SRAM pins exclusively.

## Interface
- `DATA_W`, 32: bus and SRAM data width; one of 8, 16, 32, 64. Derived `SEL_W = DATA_W/8`, `LSB = log2(SEL_W)`.
- `ADDR_W`, 20: SRAM word-address width.
- `MEM_WORDS`, 2**ADDR_W: number of populated words. Any word index >= MEM_WORDS is out of range.
- `RD_WAIT`, 1: cycles with `sram_oe` asserted before read data is sampled; must be >= 1.
- `WR_WAIT`, 1: cycles `sram_we` is held low; must be >= 1.

Ports:
- `clk_bus` in 1: bus clock; all flops on the rising edge.
- `rst_bus` in 1: asynchronous, active-low reset.
- `dat_i` in DATA_W: write data.
- `dat_o` out DATA_W: registered read data.
- `ack_o` out 1: one-cycle normal termination.
- `adr_i` in 32: byte address. Word index = `adr_i[ADDR_W+LSB-1:LSB]`.
- `cyc_i`, `stb_i`, `we_i` in 1: Wishbone classic cycle, strobe and write enable.
- `sel_i` in SEL_W: byte lane selects.
- `err_o` out 1: one-cycle error termination.
- `rty_o` out 1: constant 0.
- `sram_adr` out ADDR_W: word address.
- `sram_dat` inout DATA_W: SRAM data bus; driven only during write states, otherwise Z.
- `sram_ce`, `sram_oe`, `sram_we` out 1: active-low chip enable, output enable and write enable.
- `sram_be` out SEL_W: active-low byte enables.

## Operation
- **Reset values:** state IDLE; `ack_o`=0, `err_o`=0, `dat_o`=0; `sram_ce`=`sram_oe`=`sram_we`=1; `sram_be`=all 1; `sram_adr`=0; `sram_dat`=Z.
- **Output registration:** all SRAM strobes, `ack_o` and `err_o` are flop outputs, so pins never glitch.
- **IDLE:** on `cyc_i & stb_i`, latch word index, `sel_i`, `dat_i` and `we_i`, then:
  - if `sel_i`==0 or index >= MEM_WORDS, go to ERR;
  - else if `we_i`, go to WR_SETUP;
  - else go to RD.
- **RD:**
  - Drive `ce`=0, `oe`=0, `be`=~sel and `sram_adr`.
  - Stay for RD_WAIT cycles, using a down-counter loaded on entry.
  - On the final RD cycle, register `sram_dat` into `dat_o`. Byte lanes with sel=0 are loaded as 0.
  - Then go to ACK.
- **WR_SETUP (1 cycle):** `ce`=0, `we`=1, `oe`=1, `be`=~sel, address valid, `sram_dat` driven with latched data.
- **WR_PULSE (WR_WAIT cycles):** as WR_SETUP, but `we`=0.
- **WR_HOLD (1 cycle):** `we`=1, data and address still driven, `ce`=0. Then go to ACK.
- **ACK (1 cycle):** `ack_o`=1 if `cyc_i` is still high, else 0. SRAM deselected, bus Z. Next state IDLE.
- **ERR (1 cycle):** `err_o`=1 if `cyc_i` is still high. No SRAM strobe asserted. Next state IDLE.
- **Abort:** if `cyc_i` falls mid-access, the SRAM cycle still completes in full, so a write pulse is never truncated. Only the termination is suppressed. `dat_o` still updates on an aborted read.
- **Back-to-back:** the master must drop `stb_i` on seeing the termination. IDLE then accepts a new request at the next edge where `cyc_i & stb_i`.
- **Data bus contention:** `sram_dat` is never driven while `sram_oe`=0.

## Timing
- Request present in cycle c (sampled at the end of c):
  - read: `ack_o` high in cycle c+RD_WAIT+1;
  - write: `ack_o` high in cycle c+WR_WAIT+3;
  - error: `err_o` high in cycle c+1.
- `ack_o` and `err_o` are each exactly one cycle wide and never high together.
- `dat_o` is valid in the ACK cycle and holds until the next read.
- Reset asserted mid-operation immediately forces all outputs to their reset values, including releasing `sram_dat` and deasserting `sram_we`. After reset release, the first edge is treated as IDLE.
- Throughput: one access per RD_WAIT+2 cycles for reads and WR_WAIT+4 cycles for writes, each including the IDLE turnaround.

## Test plan
- **Reset:** pulse `rst_bus` low mid-WR_PULSE -> `sram_we`=1, `sram_dat`=Z and `ack_o`=0 immediately; no ack ever follows for that write.
- **Write then read, defaults** (DATA_W=32, RD_WAIT=1, WR_WAIT=1):
  - write 0xDEADBEEF to 0x0000_0010, sel=0xF -> `sram_adr`=4 and `sram_we` low for exactly 1 cycle, bracketed by 1 setup and 1 hold cycle; ack in c+4;
  - read back -> ack in c+2 with `dat_o`=0xDEADBEEF.
- **Byte lanes:** write 0x11223344 with sel=0b0101 -> `sram_be`=0b1010 throughout; a readback with sel=0b0101 returns 0x00220044, the model holding bytes 2 and 0.
- **Errors:**
  - MEM_WORDS=1024, access to byte address 0x1000 -> `err_o` in c+1, `sram_ce` stays 1, `ack_o` stays 0;
  - sel=0 at a valid address -> same error response.
- **Wait states** (RD_WAIT=3, WR_WAIT=2):
  - read ack in c+4 with `sram_oe` low for 3 cycles;
  - write ack in c+5 with `sram_we` low for 2 cycles.
- **Abort:** drop `cyc_i` during RD -> SRAM read completes and `dat_o` updates; `ack_o` stays 0; a next request 1 cycle later is accepted normally.
